// File: rtl/alu_mdu_pkg.sv
// Shared constants for the ALU/MDU block: opcode encodings, FSM state
// encoding and the status-flag bundle registered alongside each result.
package alu_mdu_pkg;

  // Opcode encodings seen on alu_op
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  // Control FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Status flags travel with the result registers
  typedef struct packed {
    logic zero;
    logic overflow;
    logic gtz;
    logic div_by_zero;
  } flags_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One iteration per clock; done_o is high during the final iteration and
// lo_o/hi_o then carry the finished product or quotient/remainder.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, hi_d;    // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;    // multiplier / dividend, shifts into result
  logic [WIDTH-1:0] opnd_q;        // multiplicand / divisor
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             last;

  // One shift-add or restoring-divide step from the current registers
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      if (div_trial[WIDTH]) begin
        // Trial went negative: restore, quotient bit 0
        hi_d = div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_d = div_trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Carry-out of the add shifts into the top of the high half
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign done_o = busy_q && last;
  assign lo_o   = lo_d;
  assign hi_o   = hi_d;

  // Load operands on start, then iterate WIDTH times
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= op_div_i;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= a_i;
      opnd_q <= b_i;
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (last) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative multiply/divide behind a valid/ready handshake.
// Single-cycle ops finish one edge after acceptance; MULTU and DIVU (b!=0)
// run WIDTH iterations in mdu_iter. Results are held in DONE until taken.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             gtz,
  output logic             div_by_zero
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  flags_t           flags_q, flags_d;

  logic             accept;
  logic             mdu_start, mdu_div, mdu_done;
  logic [WIDTH-1:0] mdu_lo, mdu_hi;

  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  flags_t           sc_flags;
  logic             sc_known;

  assign in_ready = !rst && ((state_q == ST_IDLE) ||
                             ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle result and flags straight from the request operands
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    sc_lo    = '0;
    sc_hi    = '0;
    sc_flags = '0;
    sc_known = 1'b1;
    case (alu_op)
      OP_ADD: begin
        sc_lo             = sum;
        sc_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo             = diff;
        sc_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        sc_flags.gtz      = !a[WIDTH-1] && (a != '0);
      end
      // Signed compare directly, so it stays correct when a-b overflows
      OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_NOR:  sc_lo = ~(a | b);
      // Only reaches the output when b==0: divide-by-zero shortcut
      OP_DIVU: begin
        sc_lo                = '1;
        sc_hi                = a;
        sc_flags.div_by_zero = 1'b1;
      end
      default: sc_known = 1'b0;
    endcase
    sc_flags.zero = sc_known && (sc_lo == '0) && (sc_hi == '0);
  end

  // Control FSM and result-register next state
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    mdu_start   = 1'b0;
    mdu_div     = 1'b0;
    case (state_q)
      ST_MUL, ST_DIV: begin
        if (mdu_done) begin
          state_d      = ST_DONE;
          result_d     = mdu_lo;
          result_hi_d  = mdu_hi;
          flags_d      = '0;
          flags_d.zero = (mdu_lo == '0) && (mdu_hi == '0);
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: ;
    endcase
    // A handshake (only possible in IDLE or a draining DONE) overrides
    if (accept) begin
      if (alu_op == OP_MULTU) begin
        state_d   = ST_MUL;
        mdu_start = 1'b1;
      end else if ((alu_op == OP_DIVU) && (b != '0)) begin
        state_d   = ST_DIV;
        mdu_start = 1'b1;
        mdu_div   = 1'b1;
      end else begin
        state_d     = ST_DONE;
        result_d    = sc_lo;
        result_hi_d = sc_hi;
        flags_d     = sc_flags;
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    // NOTE: result registers are cleared on reset so outputs read zero before the first operation.
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mdu_start),
    .op_div_i (mdu_div),
    .a_i      (a),
    .b_i      (b),
    .done_o   (mdu_done),
    .lo_o     (mdu_lo),
    .hi_o     (mdu_hi)
  );

  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = flags_q.zero;
  assign overflow    = flags_q.overflow;
  assign gtz         = flags_q.gtz;
  assign div_by_zero = flags_q.div_by_zero;

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 8 to 64).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request present.
REQ-005 SHALL have port: in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: a  input  WIDTH  first operand.
REQ-007 SHALL have port: b  input  WIDTH  second operand.
REQ-008 SHALL have port: alu_op  input  4  opcode: 0010 ADD, 0110 SUB, 0111 SLT, 0000 AND, 0001 OR, 0101 NOR, 1000 MULTU, 1001 DIVU; all others are invalid.
REQ-009 SHALL have port: out_valid  output  1  result registers hold a completed operation.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port: result  output  WIDTH  low result: sum, logic, SLT, product[WIDTH-1:0] or quotient.
REQ-012 SHALL have port: result_hi  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder; 0 for all other ops.
REQ-013 SHALL have ports: zero, overflow, gtz, div_by_zero  output  1 each  status flags registered with result.

Function
REQ-014 SHALL transfer a request only when in_valid and in_ready are both 1, capturing a, b and alu_op in that cycle.
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-017 SHALL move a handshake with ADD/SUB/SLT/AND/OR/NOR/invalid to DONE with out_valid=1 on the next edge (latency 1).
REQ-018 SHALL move MULTU to MUL, then run WIDTH iterations of unsigned shift-add, then enter DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 SHALL move DIVU with b!=0 to DIV, then run WIDTH iterations of unsigned restoring division, then enter DONE; latency is WIDTH+1.
REQ-020 SHALL complete DIVU with b==0 in 1 cycle with result all ones, result_hi=a and div_by_zero=1.
REQ-021 SHALL hold out_valid and all outputs stable in DONE until out_ready=1.
REQ-022 SHALL, when out_ready=1 in DONE with no new handshake, return to IDLE with out_valid=0.
REQ-023 SHALL, when out_ready=1 in DONE with a simultaneous new handshake, start the new operation in the same cycle, giving back-to-back single-cycle ops one result per cycle.
REQ-024 SHALL compute ADD/SUB modulo 2^WIDTH and set overflow=1 on signed overflow (ADD: equal operand signs, result sign differs; SUB: operand signs differ, result sign differs from a); overflow=0 for all other ops.
REQ-025 SHALL compute SLT as a true signed comparison a<b, correct even when a-b overflows; result is 1 or 0, zero-extended.
REQ-026 SHALL set gtz=1 only for SUB with signed a>0; gtz=0 otherwise.
REQ-027 SHALL set zero=1 when the full output is zero: {result_hi,result} for MULTU/DIVU, result otherwise.
REQ-028 SHALL return result=0 and all flags 0 for invalid opcodes, which complete normally with latency 1.
REQ-029 SHALL ignore in_valid and hold captured operands while in MUL or DIV (in_ready=0).

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE with out_valid=0, result=0, result_hi=0, all flags 0 and the iteration counter 0.
REQ-031 SHALL, on rst during MUL, DIV or DONE, abandon the operation and produce no result.
REQ-032 SHALL drive in_ready=0 in any cycle where rst=1.

Structure
REQ-033 SHALL take the opcode constants and the FSM state encoding from the shared package alu_mdu_pkg.
REQ-034 SHALL place the iterative multiply/divide datapath (accumulator, shift registers, iteration counter sized $clog2(WIDTH)+1) in sub-module mdu_iter, controlled by start/op inputs and a done output.

Verification
REQ-035 SHALL cover, WIDTH=32: ADD a=0x7FFFFFFF, b=1 -> after 1 cycle result=0x80000000, overflow=1, zero=0.
REQ-036 SHALL cover: SLT a=0x80000000, b=1 -> result=1; SUB a=5, b=5 -> result=0, zero=1, gtz=1.
REQ-037 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after acceptance, result_hi=1, result=0xFFFFFFFE.
REQ-038 SHALL cover: DIVU a=100, b=7 -> result=14, result_hi=2 after 33 cycles; DIVU a=9, b=0 -> next cycle result=0xFFFFFFFF, result_hi=9, div_by_zero=1.
REQ-039 SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with a new AND request -> next result valid on the following cycle.
REQ-040 SHALL cover: rst asserted at iteration 10 of a MULTU -> next cycle IDLE, out_valid=0, in_ready=1, and no stale result appears afterwards.
